// File: rtl/ibex_icache_line_filler.sv
// Cache-line refill engine: fetches LineBeats bus words (optionally critical-word-first),
// keeps up to MaxOutstanding requests in flight, supports abort with response drain.
module ibex_icache_line_filler #(
   parameter int unsigned BusWidth       = 32,
   parameter int unsigned LineBeats      = 2,
   parameter int unsigned MaxOutstanding = 2,
   parameter bit          CritWordFirst  = 1'b1
) (
   input  logic                          clk_i,
   input  logic                          rst_ni,
   input  logic                          fill_req_i,
   input  logic [31:0]                   fill_addr_i,
   output logic                          fill_gnt_o,
   input  logic                          abort_i,
   output logic                          instr_req_o,
   input  logic                          instr_gnt_i,
   output logic [31:0]                   instr_addr_o,
   input  logic [BusWidth-1:0]           instr_rdata_i,
   input  logic                          instr_rvalid_i,
   input  logic                          instr_err_i,
   output logic                          beat_valid_o,
   output logic [$clog2(LineBeats)-1:0]  beat_idx_o,
   output logic [BusWidth-1:0]           beat_data_o,
   output logic                          beat_err_o,
   output logic                          line_done_o,
   output logic [LineBeats*BusWidth-1:0] line_data_o,
   output logic                          line_err_o,
   output logic                          busy_o
);
   localparam int unsigned IdxW  = $clog2(LineBeats);
   localparam int unsigned CntW  = IdxW + 1;
   localparam int unsigned OutW  = 3;
   localparam int unsigned BaseW = 32 - IdxW - 2;

   typedef enum logic [1:0] {IDLE, ISSUE, DRAIN} state_e;

   state_e                        state;
   logic [BaseW-1:0]              base;
   logic [IdxW-1:0]               start;
   logic [IdxW-1:0]               rx_idx;
   logic [CntW-1:0]               issued;
   logic [OutW-1:0]               outstanding;
   logic                          hold;
   logic                          err_seen;
   logic                          aborted;
   logic [LineBeats*BusWidth-1:0] line;

   logic            accept, can_issue, req, rsp, rsp_keep;
   logic            aborted_n, err_n, hold_n, issue_end;
   logic [CntW-1:0] issued_n;
   logic [OutW-1:0] outstanding_n;
   logic [IdxW-1:0] issue_idx;
   logic            unused_addr;

   assign unused_addr = ^fill_addr_i[IdxW+1:0];

   // Bus handshake: a request transfers on req & gnt; once req is raised it and the
   // address are held (via hold) until granted, whatever abort or error does meanwhile.
   assign fill_gnt_o = rst_ni & (state == IDLE) & ~abort_i;
   assign accept     = fill_req_i & fill_gnt_o;
   assign can_issue  = (issued < CntW'(LineBeats)) & (outstanding < OutW'(MaxOutstanding))
                       & ~err_seen & ~aborted;
   assign req        = (state == ISSUE) & (hold | can_issue);
   assign issue_idx  = start + issued[IdxW-1:0];

   assign instr_req_o  = req;
   assign instr_addr_o = {base, issue_idx, 2'b00};

   // A response with nothing outstanding is ignored.
   assign rsp           = instr_rvalid_i & (outstanding != '0);
   assign aborted_n     = aborted | abort_i;
   assign rsp_keep      = rsp & ~aborted_n;
   assign err_n         = err_seen | (rsp_keep & instr_err_i);
   assign issued_n      = issued + CntW'(req & instr_gnt_i);
   assign outstanding_n = outstanding + OutW'(req & instr_gnt_i) - OutW'(rsp);
   assign hold_n        = req & ~instr_gnt_i;
   assign issue_end     = ~hold_n & ((issued_n == CntW'(LineBeats)) | err_n | aborted_n);

   assign line_data_o = line;
   assign line_err_o  = err_seen;
   assign busy_o      = (state != IDLE);

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state        <= IDLE;
         base         <= '0;
         start        <= '0;
         rx_idx       <= '0;
         issued       <= '0;
         outstanding  <= '0;
         hold         <= 1'b0;
         err_seen     <= 1'b0;
         aborted      <= 1'b0;
         line         <= '0;
         beat_valid_o <= 1'b0;
         beat_idx_o   <= '0;
         beat_data_o  <= '0;
         beat_err_o   <= 1'b0;
         line_done_o  <= 1'b0;
      end else begin
         beat_valid_o <= 1'b0;
         line_done_o  <= 1'b0;
         case (state)
            IDLE: begin
               if (accept) begin
                  base        <= fill_addr_i[31:IdxW+2];
                  start       <= CritWordFirst ? fill_addr_i[IdxW+1:2] : '0;
                  rx_idx      <= CritWordFirst ? fill_addr_i[IdxW+1:2] : '0;
                  issued      <= '0;
                  outstanding <= '0;
                  hold        <= 1'b0;
                  err_seen    <= 1'b0;
                  aborted     <= 1'b0;
                  line        <= '0;
                  state       <= ISSUE;
               end
            end
            ISSUE, DRAIN: begin
               issued      <= issued_n;
               outstanding <= outstanding_n;
               hold        <= hold_n;
               aborted     <= aborted_n;
               err_seen    <= err_n;
               // Responses return in issue order, so the slot just follows a counter.
               if (rsp) rx_idx <= rx_idx + IdxW'(1);
               if (rsp_keep) begin
                  beat_valid_o <= 1'b1;
                  beat_idx_o   <= rx_idx;
                  beat_data_o  <= instr_rdata_i;
                  beat_err_o   <= instr_err_i;
               end
               for (int i = 0; i < LineBeats; i++) begin
                  if (rsp_keep && rx_idx == IdxW'(i)) line[i*BusWidth +: BusWidth] <= instr_rdata_i;
               end
               if (issue_end && outstanding_n == '0) begin
                  state       <= IDLE;
                  line_done_o <= ~aborted_n;
               end else if (issue_end) begin
                  state <= DRAIN;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_ibex_icache_line_filler.sv
// Directed bench for ibex_icache_line_filler: three parameterisations share one bus model,
// selected by sel; beats and bus addresses are scored against hand-computed expectations.
module tb_ibex_icache_line_filler;
   logic clk, rst_n;
   int   sel;
   logic fill_req, abort;
   logic [31:0] fill_addr;
   logic gnt, rvalid, rerr;
   logic [31:0] rdata;

   // DUT outputs (0: LB2/MO2/CWF1, 1: LB4/MO2/CWF0, 2: LB4/MO1/CWF1)
   logic        req_w [3];
   logic [31:0] addr_w [3];
   logic        fgnt_w [3];
   logic        bv_w [3];
   logic        berr_w [3];
   logic [31:0] bdata_w [3];
   logic        done_w [3];
   logic        lerr_w [3];
   logic        busy_w [3];
   logic        bidx_a;
   logic [1:0]  bidx_b, bidx_c;
   logic [63:0] line_a;
   logic [127:0] line_b, line_c;

   logic        m_req, m_fgnt, m_bv, m_berr, m_done, m_lerr, m_busy;
   logic [31:0] m_addr, m_bdata;
   logic [1:0]  m_idx;
   logic [127:0] m_line;

   int n_vec, n_err;

   // bus model knobs and logs
   int lat, stall_left, stall_seen, cyc, model_outst, max_outst;
   int stab_viol, mo_viol, done_cnt, done_beat, done_cyc, last_rv_cyc, busy_fall_cyc;
   logic err_en;
   logic [31:0] err_addr, prev_addr;
   logic prev_stall, prev_busy, done_err;
   logic [127:0] done_line;
   logic pv [4];
   logic [31:0] pa [4];
   logic [31:0] addr_q[$];
   logic [34:0] beat_q[$];
   logic [31:0] exp_addr_q[$];
   logic [34:0] exp_q[$];

   ibex_icache_line_filler #(.BusWidth(32), .LineBeats(2), .MaxOutstanding(2), .CritWordFirst(1'b1)) u_a (
      .clk_i(clk), .rst_ni(rst_n), .fill_req_i(fill_req && sel == 0), .fill_addr_i(fill_addr),
      .fill_gnt_o(fgnt_w[0]), .abort_i(abort && sel == 0), .instr_req_o(req_w[0]),
      .instr_gnt_i(gnt && sel == 0), .instr_addr_o(addr_w[0]), .instr_rdata_i(rdata),
      .instr_rvalid_i(rvalid && sel == 0), .instr_err_i(rerr), .beat_valid_o(bv_w[0]),
      .beat_idx_o(bidx_a), .beat_data_o(bdata_w[0]), .beat_err_o(berr_w[0]), .line_done_o(done_w[0]),
      .line_data_o(line_a), .line_err_o(lerr_w[0]), .busy_o(busy_w[0]));

   ibex_icache_line_filler #(.BusWidth(32), .LineBeats(4), .MaxOutstanding(2), .CritWordFirst(1'b0)) u_b (
      .clk_i(clk), .rst_ni(rst_n), .fill_req_i(fill_req && sel == 1), .fill_addr_i(fill_addr),
      .fill_gnt_o(fgnt_w[1]), .abort_i(abort && sel == 1), .instr_req_o(req_w[1]),
      .instr_gnt_i(gnt && sel == 1), .instr_addr_o(addr_w[1]), .instr_rdata_i(rdata),
      .instr_rvalid_i(rvalid && sel == 1), .instr_err_i(rerr), .beat_valid_o(bv_w[1]),
      .beat_idx_o(bidx_b), .beat_data_o(bdata_w[1]), .beat_err_o(berr_w[1]), .line_done_o(done_w[1]),
      .line_data_o(line_b), .line_err_o(lerr_w[1]), .busy_o(busy_w[1]));

   ibex_icache_line_filler #(.BusWidth(32), .LineBeats(4), .MaxOutstanding(1), .CritWordFirst(1'b1)) u_c (
      .clk_i(clk), .rst_ni(rst_n), .fill_req_i(fill_req && sel == 2), .fill_addr_i(fill_addr),
      .fill_gnt_o(fgnt_w[2]), .abort_i(abort && sel == 2), .instr_req_o(req_w[2]),
      .instr_gnt_i(gnt && sel == 2), .instr_addr_o(addr_w[2]), .instr_rdata_i(rdata),
      .instr_rvalid_i(rvalid && sel == 2), .instr_err_i(rerr), .beat_valid_o(bv_w[2]),
      .beat_idx_o(bidx_c), .beat_data_o(bdata_w[2]), .beat_err_o(berr_w[2]), .line_done_o(done_w[2]),
      .line_data_o(line_c), .line_err_o(lerr_w[2]), .busy_o(busy_w[2]));

   always_comb begin
      case (sel)
         1: begin
            m_req = req_w[1]; m_addr = addr_w[1]; m_fgnt = fgnt_w[1]; m_bv = bv_w[1]; m_berr = berr_w[1];
            m_bdata = bdata_w[1]; m_done = done_w[1]; m_lerr = lerr_w[1]; m_busy = busy_w[1];
            m_idx = bidx_b; m_line = line_b;
         end
         2: begin
            m_req = req_w[2]; m_addr = addr_w[2]; m_fgnt = fgnt_w[2]; m_bv = bv_w[2]; m_berr = berr_w[2];
            m_bdata = bdata_w[2]; m_done = done_w[2]; m_lerr = lerr_w[2]; m_busy = busy_w[2];
            m_idx = bidx_c; m_line = line_c;
         end
         default: begin
            m_req = req_w[0]; m_addr = addr_w[0]; m_fgnt = fgnt_w[0]; m_bv = bv_w[0]; m_berr = berr_w[0];
            m_bdata = bdata_w[0]; m_done = done_w[0]; m_lerr = lerr_w[0]; m_busy = busy_w[0];
            m_idx = {1'b0, bidx_a}; m_line = {64'h0, line_a};
         end
      endcase
   end

   // clock / watchdog
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial begin
      #400000;
      $display("FAIL watchdog: got timeout, expected summary");
      $fatal(1, "watchdog");
   end

   task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   // bus responder and monitor: observe at negedge, then drive gnt/rvalid for the next edge
   initial begin
      gnt = 1'b0; rvalid = 1'b0; rdata = '0; rerr = 1'b0;
      prev_stall = 1'b0; prev_busy = 1'b0; prev_addr = '0;
      for (int i = 0; i < 4; i++) begin pv[i] = 1'b0; pa[i] = '0; end
      forever begin
         @(negedge clk);
         cyc++;
         if (!rst_n) begin
            gnt = 1'b0; rvalid = 1'b0; rerr = 1'b0; model_outst = 0;
            prev_stall = 1'b0; prev_busy = 1'b0;
            for (int i = 0; i < 4; i++) pv[i] = 1'b0;
         end else begin
            if (prev_stall && (!m_req || m_addr != prev_addr)) stab_viol++;
            if (m_req && model_outst >= ((sel == 2) ? 1 : 2)) mo_viol++;
            if (m_bv) beat_q.push_back({m_berr, m_idx, m_bdata});
            if (m_done) begin
               done_cnt++; done_cyc = cyc; done_line = m_line; done_err = m_lerr; done_beat = int'(m_bv);
            end
            if (prev_busy && !m_busy) busy_fall_cyc = cyc;
            prev_busy = m_busy;
            rvalid = pv[0];
            rdata  = {16'hCAFE, pa[0][15:0]};
            rerr   = pv[0] && err_en && pa[0] == err_addr;
            for (int i = 0; i < 3; i++) begin pv[i] = pv[i+1]; pa[i] = pa[i+1]; end
            pv[3] = 1'b0;
            if (rvalid) begin model_outst--; last_rv_cyc = cyc; end
            if (m_req && stall_left > 0) begin
               gnt = 1'b0; stall_left--; stall_seen++;
            end else begin
               gnt = m_req;
            end
            if (gnt) begin
               addr_q.push_back(m_addr);
               model_outst++;
               if (model_outst > max_outst) max_outst = model_outst;
               pv[lat-1] = 1'b1; pa[lat-1] = m_addr;
            end
            prev_stall = m_req && !gnt;
            prev_addr  = m_addr;
         end
      end
   end

   task automatic clear_logs();
      addr_q.delete(); beat_q.delete(); exp_addr_q.delete(); exp_q.delete();
      done_cnt = 0; done_beat = 0; done_cyc = 0; last_rv_cyc = 0; busy_fall_cyc = 0;
      stab_viol = 0; mo_viol = 0; stall_seen = 0; max_outst = 0; done_err = 1'b0; done_line = '0;
   endtask

   task automatic do_fill(input logic [31:0] a);
      int tries;
      tries = 0;
      @(negedge clk);
      fill_req = 1'b1; fill_addr = a;
      #1;
      while (!m_fgnt && tries < 20) begin @(negedge clk); #1; tries++; end
      check("fill_accept", m_fgnt, 1'b1);
      @(negedge clk);
      fill_req = 1'b0;
   endtask

   task automatic wait_idle();
      int n;
      n = 0;
      #2;
      while ((m_busy || model_outst != 0) && n < 200) begin @(negedge clk); #2; n++; end
      if (n >= 200) check("idle_timeout", 1, 0);
      @(negedge clk); #2;
   endtask

   task automatic cmp_logs();
      check("n_addr", addr_q.size(), exp_addr_q.size());
      for (int i = 0; i < exp_addr_q.size() && i < addr_q.size(); i++)
         check($sformatf("addr%0d", i), addr_q[i], exp_addr_q[i]);
      check("n_beats", beat_q.size(), exp_q.size());
      for (int i = 0; i < exp_q.size() && i < beat_q.size(); i++)
         check($sformatf("beat%0d", i), beat_q[i], exp_q[i]);
   endtask

   initial begin
      n_vec = 0; n_err = 0; cyc = 0; model_outst = 0;
      sel = 0; fill_req = 1'b0; fill_addr = '0; abort = 1'b0;
      lat = 1; stall_left = 0; err_en = 1'b0; err_addr = '0;
      clear_logs();
      rst_n = 1'b0;
      repeat (3) @(negedge clk);
      for (int s = 0; s < 3; s++) begin
         sel = s; #1;
         check("rst_busy", m_busy, 1'b0);
         check("rst_fill_gnt", m_fgnt, 1'b0);
         check("rst_line", m_line, '0);
         check("rst_outs", {m_req, m_bv, m_done, m_lerr, m_berr, m_bdata}, '0);
      end
      sel = 0;
      @(negedge clk); rst_n = 1'b1;
      repeat (2) @(negedge clk);

      // LB2 critical-word-first
      clear_logs();
      exp_addr_q = '{32'h1004, 32'h1000};
      exp_q = '{{1'b0, 2'd1, 32'hCAFE1004}, {1'b0, 2'd0, 32'hCAFE1000}};
      do_fill(32'h1004); wait_idle(); cmp_logs();
      check("t1_done_cnt", done_cnt, 1);
      check("t1_line", done_line, 128'hCAFE1004_CAFE1000);
      check("t1_line_err", done_err, 1'b0);
      check("t1_done_lat", done_cyc - last_rv_cyc, 1);
      check("t1_done_with_beat", done_beat, 1);

      // LB4 linear order, grant stalled 3 cycles
      sel = 1; clear_logs(); stall_left = 3;
      exp_addr_q = '{32'h2000, 32'h2004, 32'h2008, 32'h200C};
      exp_q = '{{1'b0, 2'd0, 32'hCAFE2000}, {1'b0, 2'd1, 32'hCAFE2004},
                {1'b0, 2'd2, 32'hCAFE2008}, {1'b0, 2'd3, 32'hCAFE200C}};
      do_fill(32'h200C); wait_idle(); cmp_logs();
      check("t2_stall_cycles", stall_seen, 3);
      check("t2_stable", stab_viol, 0);
      check("t2_done_cnt", done_cnt, 1);
      check("t2_line", done_line, 128'hCAFE200C_CAFE2008_CAFE2004_CAFE2000);

      // MO1: one transaction at a time, wrap from beat 2
      sel = 2; clear_logs();
      exp_addr_q = '{32'h3008, 32'h300C, 32'h3000, 32'h3004};
      exp_q = '{{1'b0, 2'd2, 32'hCAFE3008}, {1'b0, 2'd3, 32'hCAFE300C},
                {1'b0, 2'd0, 32'hCAFE3000}, {1'b0, 2'd1, 32'hCAFE3004}};
      do_fill(32'h3008); wait_idle(); cmp_logs();
      check("t3_max_outst", max_outst, 1);
      check("t3_req_over_limit", mo_viol, 0);
      check("t3_line", done_line, 128'hCAFE300C_CAFE3008_CAFE3004_CAFE3000);

      // error on second beat stops issue; third still captured
      sel = 1; clear_logs(); err_en = 1'b1; err_addr = 32'h4004;
      exp_addr_q = '{32'h4000, 32'h4004, 32'h4008};
      exp_q = '{{1'b0, 2'd0, 32'hCAFE4000}, {1'b1, 2'd1, 32'hCAFE4004}, {1'b0, 2'd2, 32'hCAFE4008}};
      do_fill(32'h4000); wait_idle(); cmp_logs();
      err_en = 1'b0;
      check("t4_done_cnt", done_cnt, 1);
      check("t4_line_err", done_err, 1'b1);
      check("t4_line", done_line, 128'h00000000_CAFE4008_CAFE4004_CAFE4000);
      repeat (3) @(negedge clk);
      #2 check("t4_line_hold", m_line, 128'h00000000_CAFE4008_CAFE4004_CAFE4000);

      // abort with two outstanding (latency 2), then immediate refill
      begin
         int n;
         sel = 0; clear_logs(); lat = 2;
         exp_addr_q = '{32'h1000, 32'h1004};
         do_fill(32'h1000);
         @(negedge clk); abort = 1'b1;
         @(negedge clk); abort = 1'b0;
         n = 0; #2;
         while (m_busy && n < 50) begin @(negedge clk); #2; n++; end
         check("t5_busy_drop", m_busy, 1'b0);
         cmp_logs();
         check("t5_done_cnt", done_cnt, 0);
         check("t5_max_outst", max_outst, 2);
         check("t5_busy_lat", busy_fall_cyc - last_rv_cyc, 1);
         clear_logs(); lat = 1;
         fill_req = 1'b1; fill_addr = 32'h1004;
         #1 check("t5_refill_gnt", m_fgnt, 1'b1);
         @(negedge clk); fill_req = 1'b0;
         wait_idle();
         check("t5_refill_done", done_cnt, 1);
         check("t5_refill_line", done_line, 128'hCAFE1004_CAFE1000);
      end

      // fill request together with abort in IDLE
      clear_logs();
      @(negedge clk); fill_req = 1'b1; abort = 1'b1; fill_addr = 32'h5004;
      #1 check("t6_gnt_blocked", m_fgnt, 1'b0);
      @(negedge clk); #1;
      check("t6_not_busy", m_busy, 1'b0);
      abort = 1'b0;
      #1 check("t6_gnt_open", m_fgnt, 1'b1);
      @(negedge clk); fill_req = 1'b0;
      exp_addr_q = '{32'h5004, 32'h5000};
      exp_q = '{{1'b0, 2'd1, 32'hCAFE5004}, {1'b0, 2'd0, 32'hCAFE5000}};
      wait_idle(); cmp_logs();
      check("t6_line", done_line, 128'hCAFE5004_CAFE5000);

      // reset in the middle of a fill
      sel = 1; clear_logs();
      do_fill(32'h6000);
      @(negedge clk); rst_n = 1'b0;
      #1;
      check("t7_busy", m_busy, 1'b0);
      check("t7_req", m_req, 1'b0);
      check("t7_line", m_line, '0);
      @(negedge clk); rst_n = 1'b1;
      repeat (2) @(negedge clk);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule

// File: doc/ibex_icache_line_filler.md
Name: ibex_icache_line_filler

Overview:
- Parametrised cache-line refill engine between the icache body and the instruction bus.
- Fetches one full line of LineBeats bus beats, critical-word-first, with up to MaxOutstanding bus transactions in flight.
- Supports mid-fill abort on branch, with drain of in-flight responses.
- Assembles the line and reports per-beat and per-line status, so the icache body can forward the critical word early and write the tag/data RAMs once.

Parameters:
- BusWidth, 32, instruction bus data width in bits. Must be 32.
- LineBeats, 2, beats per cache line. Power of 2, at least 2.
- MaxOutstanding, 2, maximum granted-but-unanswered bus transactions, 1 to 4.
- CritWordFirst, 1, 1 = start at the requested beat and wrap; 0 = always start at beat 0.

Ports:
- clk_i  in  1  clock
- rst_ni  in  1  asynchronous active-low reset
- fill_req_i  in  1  request a line fill
- fill_addr_i  in  32  address of the requested word
- fill_gnt_o  out  1  fill accepted this cycle (fill_req_i & fill_gnt_o)
- abort_i  in  1  cancel the current fill (branch)
- instr_req_o  out  1  bus request
- instr_gnt_i  in  1  bus grant
- instr_addr_o  out  32  bus word address
- instr_rdata_i  in  BusWidth  bus read data
- instr_rvalid_i  in  1  bus response valid
- instr_err_i  in  1  bus response error
- beat_valid_o  out  1  one beat captured (pulse)
- beat_idx_o  out  $clog2(LineBeats)  index of the captured beat within the line
- beat_data_o  out  BusWidth  captured beat data
- beat_err_o  out  1  captured beat had an error
- line_done_o  out  1  line complete (pulse)
- line_data_o  out  LineBeats*BusWidth  assembled line; beat i at bits [i*BusWidth +: BusWidth]
- line_err_o  out  1  at least one beat errored; qualified by line_done_o
- busy_o  out  1  engine not in IDLE

Behaviour:
- Reset values: all outputs 0; FSM in IDLE; all counters 0; line register 0.
- FSM states: IDLE, ISSUE, DRAIN.
- IDLE:
  - fill_gnt_o = ~abort_i.
  - On fill_req_i & fill_gnt_o: latch line base = fill_addr_i[31:log2(LineBeats)+2].
  - Start beat = fill_addr_i beat bits if CritWordFirst, else 0.
  - Clear the line error flag and all counters; go to ISSUE.
- ISSUE:
  - instr_req_o = 1 while issued < LineBeats, outstanding < MaxOutstanding, and no error has been seen.
  - instr_addr_o = {base, (start + issued) mod LineBeats, 2'b00}; the beat index wraps modulo LineBeats.
  - Once instr_req_o is high, it and instr_addr_o stay stable until instr_gnt_i, even if abort_i or an error arrives.
  - When all requests are issued, or issuing stops on abort/error, go to DRAIN.
- Outstanding counter: next = cur + (req & gnt) - rvalid. A grant and a response in the same cycle leave the count unchanged.
- instr_rvalid_i with outstanding == 0 is illegal (bench assertion); the block ignores it.
- Each non-aborted response:
  - Write the beat into the line register at the expected beat index, in issue order.
  - Next cycle: beat_valid_o = 1 with beat_idx_o, beat_data_o, beat_err_o.
  - instr_err_i sets line_err_o and stops further issue; already-outstanding responses are still captured.
- DRAIN: wait until outstanding == 0.
  - Not aborted: line_done_o pulses for 1 cycle in the cycle after the final response, together with that final beat's beat_valid_o.
  - line_data_o holds until the next accepted fill. Unfetched beats after an error are 0.
  - State returns to IDLE in the same cycle as the line_done_o pulse. fill_gnt_o may be high in that cycle, so back-to-back fills are allowed.
- Abort (abort_i while busy):
  - Set the aborted flag; stop new issue after any pending grant.
  - Discard all remaining responses: no beat_valid_o, no line_done_o.
  - Return to IDLE once outstanding == 0.
  - abort_i in IDLE has no effect other than suppressing fill_gnt_o.
  - An abort coinciding with the final response suppresses line_done_o.
- busy_o = (state != IDLE).
- Reset mid-fill: everything returns to the reset state immediately. The bus is assumed to be reset with the block.

Test Plan:
- LineBeats=2, MaxOutstanding=2, fill_addr=0x1004, gnt every cycle, rvalid 1 cycle after gnt, data A,B → addresses 0x1004 then 0x1000; beats idx1=A then idx0=B; line_data={A,B}; line_done 1 cycle after the 2nd rvalid; line_err=0.
- LineBeats=4, CritWordFirst=0, fill_addr=0x200C, gnt stalled 3 cycles → address 0x2000 held stable with req high during the stall; order 0x2000, 0x2004, 0x2008, 0x200C.
- MaxOutstanding=1, LineBeats=4 → req deasserted after each grant until the matching rvalid; never 2 outstanding.
- 2nd beat returns instr_err=1 (LineBeats=4, MaxOutstanding=2) → issue stops; outstanding 3rd beat still captured; line_done with line_err=1; 4th beat never requested; its line slot is 0.
- abort_i one cycle after the 1st grant, 2 outstanding → no beat_valid, no line_done; busy_o drops 1 cycle after the last rvalid; next fill accepted immediately after.
- fill_req and abort_i together in IDLE → fill_gnt_o=0; with abort_i low the next cycle, the fill is accepted.
